// File: rtl/can_pkg.sv
// Shared types and widths for the CAN controller MC_IF register bus.
package can_pkg;

   localparam int MC_ADDR_W = 6;
   localparam int MC_DATA_W = 32;

   typedef enum logic [2:0] {
      IDLE,
      CS,
      WAIT,
      DONE,
      GAP
   } mc_arb_state_t;

   typedef struct packed {
      logic                 r_neg_w;
      logic [MC_ADDR_W-1:0] addr;
      logic [MC_DATA_W-1:0] wdata;
   } mc_req_t;

endpackage

// File: rtl/can_mc_arbiter_if.sv
// Requester and MC_IF register-bus signals of the two-port MC_IF arbiter.
interface can_mc_arbiter_if;
   import can_pkg::*;

   logic [1:0]           i_req;
   logic [1:0]           i_req_r_neg_w;
   logic [MC_ADDR_W-1:0] i_req_addr0;
   logic [MC_ADDR_W-1:0] i_req_addr1;
   logic [MC_DATA_W-1:0] i_req_wdata0;
   logic [MC_DATA_W-1:0] i_req_wdata1;
   logic [1:0]           o_gnt;
   logic [1:0]           o_done;
   logic                 o_err;
   logic                 o_timeout;
   logic [MC_DATA_W-1:0] o_rdata;
   logic                 o_cs;
   logic [MC_ADDR_W-1:0] o_addr;
   logic                 o_r_neg_w;
   logic [MC_DATA_W-1:0] o_bus_data;
   logic [MC_DATA_W-1:0] i_reg_data;
   logic                 i_ack;
   logic                 i_error;

   modport master (
      input  i_req, i_req_r_neg_w, i_req_addr0, i_req_addr1,
      input  i_req_wdata0, i_req_wdata1, i_reg_data, i_ack, i_error,
      output o_gnt, o_done, o_err, o_timeout, o_rdata,
      output o_cs, o_addr, o_r_neg_w, o_bus_data
   );

   modport slave (
      output i_req, i_req_r_neg_w, i_req_addr0, i_req_addr1,
      output i_req_wdata0, i_req_wdata1, i_reg_data, i_ack, i_error,
      input  o_gnt, o_done, o_err, o_timeout, o_rdata,
      input  o_cs, o_addr, o_r_neg_w, o_bus_data
   );

endinterface

// File: rtl/can_rr_arbiter_2.sv
// Two-way round-robin winner select with a registered last-grant pointer.
module can_rr_arbiter_2 (
   input  logic       i_sys_clk,
   input  logic       i_reset,
   input  logic [1:0] req,
   input  logic       upd,
   output logic       win,
   output logic       any
);

   logic last;

   always_comb begin
      any = |req;
      win = 1'b0;
      if (req == 2'b11) win = ~last;
      else if (req[1]) win = 1'b1;
   end

   // last resets to the loader so the host takes the first tie
   always_ff @(posedge i_sys_clk or posedge i_reset) begin
      if (i_reset) last <= 1'b1;
      else if (upd) last <= win;
   end

endmodule

// File: rtl/can_mc_arbiter.sv
// Host/loader arbiter and transaction sequencer for the MC_IF register bus.
module can_mc_arbiter
   import can_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic               i_sys_clk,
   input  logic               i_reset,
   can_mc_arbiter_if.master   bus
);

   localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

   mc_arb_state_t state, state_nx;
   logic [7:0]    tmo_cnt;
   logic          owner;
   logic          win;
   logic          any;
   logic          grant;
   logic          rsp;
   logic          tmo_hit;
   mc_req_t       req_sel;

   can_rr_arbiter_2 u_rr (
      .i_sys_clk (i_sys_clk),
      .i_reset   (i_reset),
      .req       (bus.i_req),
      .upd       (grant),
      .win       (win),
      .any       (any)
   );

   assign grant   = (state == IDLE) && any;
   assign rsp     = bus.i_ack | bus.i_error;
   assign tmo_hit = (tmo_cnt == TO_LAST);

   always_comb begin
      req_sel.r_neg_w = bus.i_req_r_neg_w[0];
      req_sel.addr    = bus.i_req_addr0;
      req_sel.wdata   = bus.i_req_wdata0;
      if (win) begin
         req_sel.r_neg_w = bus.i_req_r_neg_w[1];
         req_sel.addr    = bus.i_req_addr1;
         req_sel.wdata   = bus.i_req_wdata1;
      end
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:    if (any) state_nx = CS;
         CS:      state_nx = WAIT;
         WAIT:    if (rsp || tmo_hit) state_nx = DONE;
         DONE:    state_nx = GAP;
         GAP:     state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge i_sys_clk or posedge i_reset) begin
      if (i_reset) state <= IDLE;
      else state <= state_nx;
   end

   always_ff @(posedge i_sys_clk or posedge i_reset) begin
      if (i_reset) begin
         bus.o_gnt      <= '0;
         bus.o_done     <= '0;
         bus.o_err      <= 1'b0;
         bus.o_timeout  <= 1'b0;
         bus.o_rdata    <= '0;
         bus.o_cs       <= 1'b0;
         bus.o_addr     <= '0;
         bus.o_r_neg_w  <= 1'b0;
         bus.o_bus_data <= '0;
         owner          <= 1'b0;
         tmo_cnt        <= '0;
      end else begin
         bus.o_gnt     <= '0;
         bus.o_done    <= '0;
         bus.o_err     <= 1'b0;
         bus.o_timeout <= 1'b0;
         bus.o_rdata   <= '0;
         bus.o_cs      <= (state_nx == CS) || (state_nx == WAIT);
         if (grant) begin
            bus.o_gnt      <= win ? 2'b10 : 2'b01;
            owner          <= win;
            bus.o_addr     <= req_sel.addr;
            bus.o_r_neg_w  <= req_sel.r_neg_w;
            bus.o_bus_data <= req_sel.wdata;
         end
         if (state == CS) tmo_cnt <= '0;
         else if (state == WAIT && tmo_cnt != 8'hFF) tmo_cnt <= tmo_cnt + 8'd1;
         // error beats ack; no response at all means timeout
         if (state == WAIT && state_nx == DONE) begin
            bus.o_done    <= owner ? 2'b10 : 2'b01;
            bus.o_err     <= bus.i_error | ~rsp;
            bus.o_timeout <= ~rsp;
            if (bus.o_r_neg_w && bus.i_ack && !bus.i_error)
               bus.o_rdata <= bus.i_reg_data;
         end
      end
   end

endmodule

// File: tb/tb_can_mc_arbiter.sv
// Directed bench for can_mc_arbiter with hand-computed expectations.
module tb_can_mc_arbiter;

   localparam int TMO = 16;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_tests = 0;
   int   n_fail  = 0;

   always #5 clk = ~clk;

   can_mc_arbiter_if mc ();

   can_mc_arbiter #(.TIMEOUT_CYCLES(TMO)) dut (
      .i_sys_clk (clk),
      .i_reset   (rst),
      .bus       (mc)
   );

   task automatic chk(input string tag, input logic [31:0] act,
                      input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h want 0x%0h", tag, act, exp);
      end
   endtask

   task automatic xact(input int who, input logic rnw,
                       input logic [5:0] addr, input logic [31:0] wd,
                       input int nwait, input logic ack, input logic err,
                       input logic [31:0] rd, input logic exp_err,
                       input logic exp_to, input logic [31:0] exp_rd);
      logic [1:0] oh;
      int c;
      int exp_c;
      oh = (who == 1) ? 2'b10 : 2'b01;
      exp_c = (nwait == 0) ? TMO + 1 : nwait + 1;
      if (who == 0) begin
         mc.i_req_addr0  = addr;
         mc.i_req_wdata0 = wd;
      end else begin
         mc.i_req_addr1  = addr;
         mc.i_req_wdata1 = wd;
      end
      mc.i_req_r_neg_w[who] = rnw;
      mc.i_req = oh;
      @(negedge clk);
      chk("gnt", 32'(mc.o_gnt), 32'(oh));
      chk("cs_on", 32'(mc.o_cs), 32'd1);
      chk("addr", 32'(mc.o_addr), 32'(addr));
      chk("bus_data", mc.o_bus_data, wd);
      chk("r_neg_w", 32'(mc.o_r_neg_w), 32'(rnw));
      mc.i_req = 2'b00;
      c = 0;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         mc.i_ack   = 1'b0;
         mc.i_error = 1'b0;
         if (mc.o_done != 2'b00) begin
            c = k;
            break;
         end
         if (k == nwait) begin
            mc.i_ack      = ack;
            mc.i_error    = err;
            mc.i_reg_data = rd;
         end
      end
      chk("done_cycle", 32'(c), 32'(exp_c));
      chk("done", 32'(mc.o_done), 32'(oh));
      chk("err", 32'(mc.o_err), 32'(exp_err));
      chk("timeout", 32'(mc.o_timeout), 32'(exp_to));
      chk("rdata", mc.o_rdata, exp_rd);
      chk("cs_off", 32'(mc.o_cs), 32'd0);
      @(negedge clk);
      chk("gap_cs", 32'(mc.o_cs), 32'd0);
      chk("gap_done", 32'(mc.o_done), 32'd0);
      @(negedge clk);
   endtask

   initial begin
      int k;
      mc.i_req         = '0;
      mc.i_req_r_neg_w = '0;
      mc.i_req_addr0   = '0;
      mc.i_req_addr1   = '0;
      mc.i_req_wdata0  = '0;
      mc.i_req_wdata1  = '0;
      mc.i_reg_data    = '0;
      mc.i_ack         = 1'b0;
      mc.i_error       = 1'b0;

      repeat (3) @(negedge clk);
      chk("rst_gnt", 32'(mc.o_gnt), 32'd0);
      chk("rst_done", 32'(mc.o_done), 32'd0);
      chk("rst_err", 32'(mc.o_err), 32'd0);
      chk("rst_to", 32'(mc.o_timeout), 32'd0);
      chk("rst_cs", 32'(mc.o_cs), 32'd0);
      chk("rst_rnw", 32'(mc.o_r_neg_w), 32'd0);
      chk("rst_addr", 32'(mc.o_addr), 32'd0);
      chk("rst_data", mc.o_bus_data, 32'd0);
      chk("rst_rdata", mc.o_rdata, 32'd0);
      rst = 1'b0;
      @(negedge clk);

      xact(0, 1'b0, 6'h05, 32'hDEADBEEF, 2, 1'b1, 1'b0, 32'h0,
           1'b0, 1'b0, 32'h0);
      xact(1, 1'b1, 6'h1E, 32'h0, 1, 1'b1, 1'b0, 32'h12345678,
           1'b0, 1'b0, 32'h12345678);
      xact(0, 1'b1, 6'h2A, 32'h0, 0, 1'b0, 1'b0, 32'h0,
           1'b1, 1'b1, 32'h0);
      xact(1, 1'b1, 6'h11, 32'h0, 1, 1'b1, 1'b1, 32'hCAFEF00D,
           1'b1, 1'b0, 32'h0);

      mc.i_ack = 1'b1;
      mc.i_reg_data = 32'h55AA55AA;
      repeat (3) begin
         @(negedge clk);
         chk("spur_done", 32'(mc.o_done), 32'd0);
         chk("spur_cs", 32'(mc.o_cs), 32'd0);
      end
      mc.i_ack = 1'b0;

      rst = 1'b1;
      @(negedge clk);
      mc.i_req_r_neg_w = 2'b00;
      mc.i_req_addr0   = 6'h01;
      mc.i_req_addr1   = 6'h02;
      mc.i_req         = 2'b11;
      rst = 1'b0;
      for (int t = 0; t < 4; t++) begin
         k = 0;
         for (int j = 1; j <= 10; j++) begin
            @(negedge clk);
            if (mc.o_gnt != 2'b00) begin
               k = j;
               break;
            end
         end
         chk("rr_gnt", 32'(mc.o_gnt), (t % 2 == 1) ? 32'd2 : 32'd1);
         chk("rr_cs", 32'(mc.o_cs), 32'd1);
         if (t > 0) chk("rr_spacing", 32'(k), 32'd2);
         @(negedge clk);
         mc.i_ack = 1'b1;
         @(negedge clk);
         mc.i_ack = 1'b0;
         chk("rr_done", 32'(mc.o_done), (t % 2 == 1) ? 32'd2 : 32'd1);
         @(negedge clk);
         chk("rr_gap_cs", 32'(mc.o_cs), 32'd0);
      end
      mc.i_req = 2'b00;
      repeat (2) @(negedge clk);

      mc.i_req_wdata0 = 32'h0BADF00D;
      mc.i_req = 2'b01;
      @(negedge clk);
      chk("rw_gnt", 32'(mc.o_gnt), 32'd1);
      mc.i_req = 2'b00;
      @(negedge clk);
      chk("rw_wait_cs", 32'(mc.o_cs), 32'd1);
      mc.i_req = 2'b11;
      #2 rst = 1'b1;
      #1 chk("rw_cs_async", 32'(mc.o_cs), 32'd0);
      @(negedge clk);
      chk("rw_done0", 32'(mc.o_done), 32'd0);
      @(negedge clk);
      chk("rw_done1", 32'(mc.o_done), 32'd0);
      rst = 1'b0;
      @(negedge clk);
      chk("rw_regnt", 32'(mc.o_gnt), 32'd1);
      mc.i_req = 2'b00;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
